// File: rtl/tdpu_gemv_sched_pkg.sv
// tdpu_gemv_sched_pkg: shared types and default sizes for the ternary GEMV scheduler
package tdpu_gemv_sched_pkg;
  localparam int DEF_LEN        = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROW_W      = 10;
  localparam int DEF_CHUNK_W    = 8;
  localparam int DEF_WADDR_W    = 18;
  localparam int DEF_ACC_W      = 32;
  typedef enum logic [1:0] {W_ZERO = 2'b00, W_POS = 2'b01, W_NEG = 2'b11} weight_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} sched_state_t;
endpackage

// File: rtl/tdpu_gemv_sched_if.sv
// tdpu_gemv_sched_if: memory read ports and core stream between the scheduler and its surroundings
interface tdpu_gemv_sched_if import tdpu_gemv_sched_pkg::*; #(
  parameter int LEN        = DEF_LEN,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHUNK_W    = DEF_CHUNK_W,
  parameter int WADDR_W    = DEF_WADDR_W
) ();
  logic                             w_rd_en;
  logic [WADDR_W-1:0]               w_rd_addr;
  weight_t [LEN-1:0]                w_rd_data;
  logic                             x_rd_en;
  logic [CHUNK_W-1:0]               x_rd_addr;
  logic [LEN-1:0][DATA_WIDTH-1:0]   x_rd_data;
  logic                             core_load_weight;
  weight_t [LEN-1:0]                core_weight;
  logic                             core_data_valid;
  logic [LEN-1:0][DATA_WIDTH-1:0]   core_data;
  logic signed [31:0]               core_result;
  logic                             core_ready;
  modport master (
    output w_rd_en, w_rd_addr, x_rd_en, x_rd_addr, core_load_weight, core_weight, core_data_valid, core_data,
    input  w_rd_data, x_rd_data, core_result, core_ready
  );
  modport slave (
    input  w_rd_en, w_rd_addr, x_rd_en, x_rd_addr, core_load_weight, core_weight, core_data_valid, core_data,
    output w_rd_data, x_rd_data, core_result, core_ready
  );
endinterface

// File: rtl/tdpu_gemv_sched_row_accumulator.sv
// tdpu_row_accumulator: sums KC core results per row and emits one registered row result
module tdpu_row_accumulator import tdpu_gemv_sched_pkg::*; #(
  parameter int ROW_W   = DEF_ROW_W,
  parameter int CHUNK_W = DEF_CHUNK_W,
  parameter int ACC_W   = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic [CHUNK_W-1:0]      i_num_chunks,
  input  logic                    i_core_ready,
  input  logic signed [31:0]      i_core_result,
  output logic                    o_row_valid,
  output logic [ROW_W-1:0]        o_row_idx,
  output logic signed [ACC_W-1:0] o_row_result
);
  logic [CHUNK_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_nx, res_d;
  logic hit, last, valid_d;
  always_comb begin
    hit     = i_en && i_core_ready;
    last    = cnt_q == i_num_chunks - 1'b1;
    acc_nx  = (cnt_q == '0 ? '0 : acc_q) + ACC_W'(i_core_result);
    cnt_d   = i_clr ? '0 : hit ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    row_d   = i_clr ? '0 : hit && last ? row_q + 1'b1 : row_q;
    acc_d   = hit ? acc_nx : acc_q;
    valid_d = hit && last;
    res_d   = valid_d ? acc_nx : o_row_result;
    idx_d   = valid_d ? row_q : o_row_idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q        <= '0;
      row_q        <= '0;
      acc_q        <= '0;
      o_row_valid  <= 1'b0;
      o_row_idx    <= '0;
      o_row_result <= '0;
    end else begin
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      acc_q        <= acc_d;
      o_row_valid  <= valid_d;
      o_row_idx    <= idx_d;
      o_row_result <= res_d;
    end
endmodule

// File: rtl/tdpu_gemv_sched.sv
// tdpu_gemv_sched: streams M x KC ternary weight chunks and KC activation chunks into one core, one chunk per cycle
module tdpu_gemv_sched import tdpu_gemv_sched_pkg::*; #(
  parameter int LEN        = DEF_LEN,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int CHUNK_W    = DEF_CHUNK_W,
  parameter int WADDR_W    = DEF_WADDR_W,
  parameter int ACC_W      = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [ROW_W-1:0]        i_num_rows,
  input  logic [CHUNK_W-1:0]      i_num_chunks,
  output logic                    o_busy,
  output logic                    o_done,
  tdpu_gemv_sched_if.master       bus,
  output logic                    o_row_valid,
  output logic [ROW_W-1:0]        o_row_idx,
  output logic signed [ACC_W-1:0] o_row_result
);
  sched_state_t state_q, state_d;
  logic [ROW_W-1:0] m_q, m_d, r_q, r_d;
  logic [CHUNK_W-1:0] kc_q, kc_d, c_q, c_d, x_addr_q, x_addr_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic w_en_q, w_en_d, ld_q, dv_q, busy_q, busy_d, done_q, done_d, go, last_beat, chunk_wrap;
  always_comb begin
    go         = state_q == S_IDLE && i_start;
    chunk_wrap = c_q == kc_q - 1'b1;
    last_beat  = r_q == m_q - 1'b1 && chunk_wrap;
    state_d    = state_q;
    m_d        = m_q;
    kc_d       = kc_q;
    r_d        = r_q;
    c_d        = c_q;
    addr_d     = addr_q;
    w_en_d     = w_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    x_addr_d   = w_en_q ? c_q : x_addr_q;
    case (state_q)
      S_IDLE: if (i_start) begin
        m_d    = i_num_rows;
        kc_d   = i_num_chunks;
        r_d    = '0;
        c_d    = '0;
        addr_d = '0;
        if (i_num_rows != '0 && i_num_chunks != '0) begin
          state_d = S_ISSUE;
          w_en_d  = 1'b1;
          busy_d  = 1'b1;
        end else done_d = 1'b1;
      end
      S_ISSUE: if (last_beat) begin
        state_d = S_DRAIN;
        w_en_d  = 1'b0;
      end else begin
        c_d    = chunk_wrap ? '0 : c_q + 1'b1;
        r_d    = chunk_wrap ? r_q + 1'b1 : r_q;
        addr_d = addr_q + 1'b1;
      end
      S_DRAIN: if (o_row_valid && o_row_idx == m_q - 1'b1) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // load/data strobes are pure delays of the weight read, so the core sees a gap-free stream
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      kc_q     <= '0;
      r_q      <= '0;
      c_q      <= '0;
      addr_q   <= '0;
      x_addr_q <= '0;
      w_en_q   <= 1'b0;
      ld_q     <= 1'b0;
      dv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      kc_q     <= kc_d;
      r_q      <= r_d;
      c_q      <= c_d;
      addr_q   <= addr_d;
      x_addr_q <= x_addr_d;
      w_en_q   <= w_en_d;
      ld_q     <= w_en_q;
      dv_q     <= ld_q;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  assign bus.w_rd_en          = w_en_q;
  assign bus.w_rd_addr        = addr_q;
  assign bus.x_rd_en          = ld_q;
  assign bus.x_rd_addr        = x_addr_q;
  assign bus.core_load_weight = ld_q;
  assign bus.core_weight      = bus.w_rd_data;
  assign bus.core_data_valid  = dv_q;
  assign bus.core_data        = (LEN*DATA_WIDTH)'(bus.x_rd_data);
  assign o_busy               = busy_q;
  assign o_done               = done_q;
  tdpu_row_accumulator #(.ROW_W(ROW_W), .CHUNK_W(CHUNK_W), .ACC_W(ACC_W)) u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (state_q != S_IDLE),
    .i_clr        (go),
    .i_num_chunks (kc_q),
    .i_core_ready (bus.core_ready),
    .i_core_result(bus.core_result),
    .o_row_valid  (o_row_valid),
    .o_row_idx    (o_row_idx),
    .o_row_result (o_row_result)
  );
endmodule

// File: tb/tb_tdpu_gemv_sched.sv
// tb_tdpu_gemv_sched: scoreboard bench with behavioural memories and core; instance 1 uses a 16-bit accumulator
module tb_tdpu_gemv_sched;
  import tdpu_gemv_sched_pkg::*;
  localparam int LEN = 16, DW = 8, ROW_W = 10, CHUNK_W = 8, WADDR_W = 18, LAT = $clog2(LEN) + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] start = '0, w_en, x_en, ld, dv, busy, done, rowv;
  logic [ROW_W-1:0] nrows [2];
  logic [CHUNK_W-1:0] nchunks [2];
  logic [WADDR_W-1:0] w_addr [2];
  logic [ROW_W-1:0] row_idx [2];
  logic [31:0] res [2];
  weight_t [LEN-1:0] wmem [256];
  logic [LEN-1:0][DW-1:0] xmem [256];
  logic [63:0] exp_q [$];
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] dot(input logic [LEN-1:0][1:0] w, input logic [LEN-1:0][DW-1:0] x);
    int s;
    s = 0;
    for (int i = 0; i < LEN; i++) begin
      if (w[i] == W_POS) s += int'($signed(x[i]));
      else if (w[i] == W_NEG) s -= int'($signed(x[i]));
    end
    return s;
  endfunction

  function automatic logic [31:0] wrapx(input longint v, input int aw);
    longint t;
    t = (v <<< (64 - aw)) >>> (64 - aw);
    return 32'(t);
  endfunction

  function automatic weight_t tern(input int v);
    if (v == 1) return W_POS;
    if (v == 2) return W_NEG;
    return W_ZERO;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int AW = g == 0 ? 32 : 16;
    tdpu_gemv_sched_if #(.LEN(LEN), .DATA_WIDTH(DW), .CHUNK_W(CHUNK_W), .WADDR_W(WADDR_W)) bus ();
    logic signed [AW-1:0] r;
    weight_t [LEN-1:0] wdat;
    logic [LEN-1:0][DW-1:0] xdat;
    logic [LEN-1:0][1:0] wreg;
    logic signed [31:0] pipe [LAT];
    logic [LAT-1:0] vld;
    tdpu_gemv_sched #(.LEN(LEN), .DATA_WIDTH(DW), .ROW_W(ROW_W), .CHUNK_W(CHUNK_W),
                      .WADDR_W(WADDR_W), .ACC_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start[g]), .i_num_rows(nrows[g]), .i_num_chunks(nchunks[g]),
      .o_busy(busy[g]), .o_done(done[g]), .bus(bus),
      .o_row_valid(rowv[g]), .o_row_idx(row_idx[g]), .o_row_result(r));
    always_ff @(posedge clk) begin
      if (bus.w_rd_en) wdat <= wmem[bus.w_rd_addr[7:0]];
      if (bus.x_rd_en) xdat <= xmem[bus.x_rd_addr];
    end
    // core model: data_valid uses the weights held before any same-cycle load
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        wreg <= '0;
        vld  <= '0;
      end else begin
        if (bus.core_load_weight) wreg <= bus.core_weight;
        vld <= {vld[LAT-2:0], bus.core_data_valid};
      end
    always_ff @(posedge clk) begin
      pipe[0] <= dot(wreg, bus.core_data);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.w_rd_data   = wdat;
    assign bus.x_rd_data   = xdat;
    assign bus.core_result = pipe[LAT-1];
    assign bus.core_ready  = vld[LAT-1];
    assign w_en[g]   = bus.w_rd_en;
    assign x_en[g]   = bus.x_rd_en;
    assign ld[g]     = bus.core_load_weight;
    assign dv[g]     = bus.core_data_valid;
    assign w_addr[g] = bus.w_rd_addr;
    assign res[g]    = 32'(r);
    always @(negedge clk) if (rowv[g]) begin
      logic [63:0] e;
      if (exp_q.size() == 0) check("row_unexpected", 64'(rowv[g]), 0);
      else begin
        e = exp_q.pop_front();
        check("row_idx", 64'(row_idx[g]), 64'(e[63:32]));
        check("row_result", 64'(res[g]), 64'(e[31:0]));
      end
    end
  end

  task automatic push_rows(input int g, input int m, input int kc);
    longint s;
    for (int r = 0; r < m; r++) begin
      s = 0;
      for (int c = 0; c < kc; c++) s += longint'(dot(wmem[r*kc+c], xmem[c]));
      exp_q.push_back({32'(r), wrapx(s, g == 0 ? 32 : 16)});
    end
  endtask

  task automatic fill_rand(input int m, input int kc);
    for (int a = 0; a < m*kc; a++)
      for (int i = 0; i < LEN; i++) wmem[a][i] = tern($urandom_range(2));
    for (int c = 0; c < kc; c++)
      for (int i = 0; i < LEN; i++) xmem[c][i] = DW'($urandom);
  endtask

  task automatic run(input int g, input int m, input int kc, input bit poke, input string tag);
    int n, wcnt, dvcnt, dvruns, cyc, row_cyc;
    bit addr_ok, prev_dv, got_done;
    n = m*kc; wcnt = 0; dvcnt = 0; dvruns = 0; row_cyc = -1;
    addr_ok = 1; prev_dv = 0; got_done = 0;
    nrows[g] = ROW_W'(m); nchunks[g] = CHUNK_W'(kc); start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    if (n != 0) check({tag, "_busy_start"}, 64'(busy[g]), 1);
    for (cyc = 0; cyc < n + 60; cyc++) begin
      if (poke && cyc == 2) begin start[g] = 1'b1; nrows[g] = 5; nchunks[g] = 5; end
      if (poke && cyc == 3) begin start[g] = 1'b0; nrows[g] = ROW_W'(m); nchunks[g] = CHUNK_W'(kc); end
      if (w_en[g]) begin
        if (w_addr[g] != WADDR_W'(wcnt)) addr_ok = 0;
        wcnt++;
      end
      if (dv[g]) begin
        dvcnt++;
        if (!prev_dv) dvruns++;
      end
      prev_dv = dv[g];
      if (rowv[g]) row_cyc = cyc;
      if (done[g]) begin got_done = 1; break; end
      @(negedge clk);
    end
    check({tag, "_done"}, 64'(got_done), 1);
    check({tag, "_w_reads"}, 64'(wcnt), 64'(n));
    check({tag, "_w_addr_seq"}, 64'(addr_ok), 1);
    check({tag, "_data_valid"}, 64'(dvcnt), 64'(n));
    if (n != 0) begin
      check({tag, "_dv_contig"}, 64'(dvruns), 1);
      check({tag, "_done_lat"}, 64'(cyc - row_cyc), 1);
    end else check({tag, "_done_lat"}, 64'(cyc), 0);
    check({tag, "_busy_end"}, 64'(busy[g]), 0);
    check({tag, "_rows_left"}, 64'(exp_q.size()), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done[g]), 0);
  endtask

  initial begin
    nrows[0] = '0; nrows[1] = '0; nchunks[0] = '0; nchunks[1] = '0;
    repeat (2) @(negedge clk);
    check("rst_strobes", 64'({w_en, x_en, ld, dv, busy, done, rowv}), 0);
    check("rst_addr", 64'(w_addr[0]), 0);
    check("rst_row", 64'({row_idx[0], res[0]}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < LEN; i++) begin wmem[0][i] = W_POS; xmem[0][i] = DW'(i + 1); end
    push_rows(0, 1, 1);
    run(0, 1, 1, 0, "t1");
    for (int a = 0; a < 6; a++)
      for (int i = 0; i < LEN; i++) wmem[a][i] = tern(a < 3 ? 2 : 0);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < LEN; i++) xmem[c][i] = 8'd5;
    push_rows(0, 2, 3);
    run(0, 2, 3, 0, "t2");
    fill_rand(4, 2);
    push_rows(0, 4, 2);
    run(0, 4, 2, 1, "t3");
    run(0, 2, 0, 0, "kc0");
    fill_rand(3, 4);
    nrows[0] = 3; nchunks[0] = 4; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_beat", 64'(w_addr[0]), 5);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", 64'({w_en, x_en, ld, dv, busy, done, rowv}), 0);
    check("abort_addr", 64'(w_addr[0]), 0);
    check("abort_row", 64'({row_idx[0], res[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_rows(0, 3, 4);
    run(0, 3, 4, 0, "t5");
    for (int a = 0; a < 255; a++)
      for (int i = 0; i < LEN; i++) begin wmem[a][i] = W_POS; xmem[a][i] = 8'h80; end
    push_rows(1, 1, 255);
    run(1, 1, 255, 0, "wrap_full");
    for (int a = 0; a < 255; a++)
      for (int i = 0; i < LEN; i++) wmem[a][i] = tern(i == 0 ? 1 : 0);
    push_rows(1, 1, 255);
    run(1, 1, 255, 0, "wrap_one");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
